// File: rtl/decode_operand_stage.sv
// Decode/operand-fetch stage: resolves register operands through a priority
// forwarding network, substitutes PC for RIP, and registers the result toward execute.
module decode_operand_stage #(
  parameter int REG_N   = 16,
  parameter int REG_W   = 64,
  parameter int OPND_N  = 3,
  parameter int FWD_LD  = 3,
  parameter int OP_W    = 8,
  parameter int PC_W    = 64,
  parameter int RIP_IDX = 16,
  parameter int PC_INC  = 1,
  parameter int NOP_OP  = 0,
  parameter int CNT_W   = 16,
  localparam int IDX_W  = $clog2(REG_N + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [OP_W-1:0]           in_op,
  input  logic [PC_W-1:0]           in_pc,
  input  logic [OPND_N*IDX_W-1:0]   in_idx,
  output logic [OPND_N*IDX_W-1:0]   gpr_rd_idx,
  input  logic [OPND_N*REG_W-1:0]   gpr_rd_val,
  input  logic [FWD_LD-1:0]         fwd_vld,
  input  logic [FWD_LD-1:0]         fwd_pend,
  input  logic [FWD_LD*IDX_W-1:0]   fwd_idx,
  input  logic [FWD_LD*REG_W-1:0]   fwd_val,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [OP_W-1:0]           out_op,
  output logic [PC_W-1:0]           out_pc,
  output logic [OPND_N*REG_W-1:0]   out_val,
  output logic [CNT_W-1:0]          hazard_cnt
);

  localparam logic [IDX_W-1:0] RIP_I    = IDX_W'(RIP_IDX);
  localparam logic [PC_W-1:0]  PC_INC_V = PC_W'(PC_INC);
  localparam logic [OP_W-1:0]  NOP_V    = OP_W'(NOP_OP);

  logic [PC_W-1:0]          pc_rip;
  logic [OPND_N*REG_W-1:0]  res_val;
  logic [OPND_N-1:0]        res_pend;
  logic                     hazard;
  logic                     take;

  logic                     valid_q, valid_d;
  logic [OP_W-1:0]          op_q,    op_d;
  logic [PC_W-1:0]          pc_q,    pc_d;
  logic [OPND_N*REG_W-1:0]  val_q,   val_d;
  logic [CNT_W-1:0]         cnt_q,   cnt_d;

  assign gpr_rd_idx = in_idx;
  assign pc_rip     = in_pc + PC_INC_V;

  // Sources are scanned oldest to youngest so the youngest match is the last
  // assignment; its pending flag therefore also wins over any older ready value.
  always_comb begin
    res_val  = '0;
    res_pend = '0;
    for (int k = 0; k < OPND_N; k++) begin
      if (in_idx[k*IDX_W +: IDX_W] == RIP_I) begin
        res_val[k*REG_W +: REG_W] = REG_W'(pc_rip);
      end else begin
        res_val[k*REG_W +: REG_W] = gpr_rd_val[k*REG_W +: REG_W];
        for (int j = FWD_LD - 1; j >= 0; j--) begin
          if (fwd_vld[j] && (fwd_idx[j*IDX_W +: IDX_W] == in_idx[k*IDX_W +: IDX_W])) begin
            res_val[k*REG_W +: REG_W] = fwd_val[j*REG_W +: REG_W];
            res_pend[k]               = fwd_pend[j];
          end
        end
      end
    end
  end

  assign hazard   = in_valid & (|res_pend);
  assign in_ready = (~valid_q | out_ready) & ~hazard & ~flush;
  assign take     = in_valid & in_ready;

  always_comb begin
    valid_d = valid_q;
    op_d    = op_q;
    pc_d    = pc_q;
    val_d   = val_q;
    if (flush) begin
      valid_d = 1'b0;
      op_d    = NOP_V;
      val_d   = '0;
    end else if (take) begin
      valid_d = 1'b1;
      op_d    = in_op;
      pc_d    = in_pc;
      val_d   = res_val;
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
      op_d    = NOP_V;
      val_d   = '0;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (hazard && !flush && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Output register stage toward execute
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      op_q    <= NOP_V;
      pc_q    <= '0;
      val_q   <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      op_q    <= op_d;
      pc_q    <= pc_d;
      val_q   <= val_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_valid  = valid_q;
  assign out_op     = op_q;
  assign out_pc     = pc_q;
  assign out_val    = val_q;
  assign hazard_cnt = cnt_q;

endmodule
